// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants for the VGA pixel pipelines.
// The frame counter in vga_timing_gen is enabled by defining VGA_FRAME_COUNT_EN.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int POS_W     = 10;
    localparam int FRAME_W   = 8;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    function automatic logic in_range(input int p, input int lo, input int hi);
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe and next-state
// decodes of the display window and sync pulse for the parent to register.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY = H_DISPLAY,
    parameter int FRONT   = H_FRONT,
    parameter int SYNC    = H_SYNC,
    parameter int BACK    = H_BACK,
    parameter int W       = POS_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         active,
    output logic         sync_pulse
);

    localparam int            TOTAL = DISPLAY + FRONT + SYNC + BACK;
    localparam logic [W-1:0]  LAST  = W'(TOTAL - 1);

    logic [W-1:0] pos_q;
    logic [W-1:0] pos_d;

    // active/sync_pulse describe pos_d so the parent's registers line up with pos_q
    always_comb begin
        pos_d = pos_q;
        wrap  = 1'b0;
        if (advance) begin
            if (pos_q == LAST) begin
                pos_d = {W{1'b0}};
                wrap  = 1'b1;
            end else begin
                pos_d = pos_q + W'(1'b1);
            end
        end else begin
            pos_d = pos_q;
        end
        active     = in_range(int'(pos_d), 32'sd0, DISPLAY - 1);
        sync_pulse = in_range(int'(pos_d), DISPLAY + FRONT, DISPLAY + FRONT + SYNC - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q <= LAST;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: registered syncs, display window, coordinates and strobes.
// Define VGA_FRAME_COUNT_EN to implement the visible-frame counter; otherwise it reads 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK    = vga_timing_pkg::H_BACK,
    parameter int   V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK    = vga_timing_pkg::V_BACK,
    parameter logic SYNC_POL  = vga_timing_pkg::SYNC_ACTIVE_LOW,
    parameter int   POS_W     = vga_timing_pkg::POS_W,
    parameter int   FRAME_W   = vga_timing_pkg::FRAME_W
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [POS_W-1:0]   hpos,
    output logic [POS_W-1:0]   vpos,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_count
);

    logic h_wrap_s, h_active_s, h_sync_s;
    logic v_wrap_s, v_active_s, v_sync_s;

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(POS_W)
    ) u_h_axis (
        .clk(clk), .rst_n(rst_n), .advance(1'b1),
        .pos(hpos), .wrap(h_wrap_s), .active(h_active_s), .sync_pulse(h_sync_s)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(POS_W)
    ) u_v_axis (
        .clk(clk), .rst_n(rst_n), .advance(h_wrap_s),
        .pos(vpos), .wrap(v_wrap_s), .active(v_active_s), .sync_pulse(v_sync_s)
    );

    logic hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q, vblank_start_q;
    logic hsync_d, vsync_d, display_on_d, line_start_d, frame_start_d, vblank_start_d;

    // A horizontal wrap means the next hpos is 0, so it is exactly the line-start condition
    always_comb begin
        hsync_d        = h_sync_s ? SYNC_POL : ~SYNC_POL;
        vsync_d        = v_sync_s ? SYNC_POL : ~SYNC_POL;
        display_on_d   = h_active_s & v_active_s;
        line_start_d   = h_wrap_s;
        frame_start_d  = h_wrap_s & v_wrap_s;
        vblank_start_d = h_wrap_s & (vpos == POS_W'(V_DISPLAY - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q        <= ~SYNC_POL;
            vsync_q        <= ~SYNC_POL;
            display_on_q   <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            display_on_q   <= display_on_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign display_on   = display_on_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [FRAME_W-1:0] frame_count_q;
    logic [FRAME_W-1:0] frame_count_d;

    // Advances on the same edge that raises vblank_start
    always_comb begin
        if (vblank_start_d) begin
            frame_count_d = frame_count_q + FRAME_W'(1'b1);
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count_q <= {FRAME_W{1'b0}};
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = {FRAME_W{1'b0}};
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instance for line-level timing, plus a
// shrunken 16x11 instance so frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif

    // small instance: H 8+2+3+3=16, V 6+1+2+2=11, frame = 176 clks
    localparam int S_FRAME = 176;
    localparam int N_END   = 255 * S_FRAME + 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       hsync, vsync, display_on, line_start, frame_start, vblank_start;
    logic [9:0] hpos, vpos;
    logic [7:0] frame_count;
    logic       s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start, s_vblank_start;
    logic [9:0] s_hpos, s_vpos;
    logic [7:0] s_frame_count;

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos), .line_start(line_start), .frame_start(frame_start),
        .vblank_start(vblank_start), .frame_count(frame_count)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .hsync(s_hsync), .vsync(s_vsync), .display_on(s_display_on),
        .hpos(s_hpos), .vpos(s_vpos), .line_start(s_line_start), .frame_start(s_frame_start),
        .vblank_start(s_vblank_start), .frame_count(s_frame_count)
    );

    typedef struct {
        int n;
        int h;
        int v;
        bit d, hs, vs, ls, fs, vb;
    } vec_t;

    vec_t vecs[14];
    int checks = 0;
    int failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] pack_exp(input int h, input int v, input bit d, input bit hs,
                                             input bit vs, input bit ls, input bit fs, input bit vb);
        return {10'(h), 10'(v), d, hs, vs, ls, fs, vb};
    endfunction

    function automatic logic [25:0] big_act();
        return {hpos, vpos, display_on, hsync, vsync, line_start, frame_start, vblank_start};
    endfunction

    function automatic logic [25:0] small_act();
        return {s_hpos, s_vpos, s_display_on, s_hsync, s_vsync, s_line_start, s_frame_start, s_vblank_start};
    endfunction

    // Small-instance reference derived from the cycle index after reset release
    function automatic logic [33:0] small_model(input int n);
        int h, v, fc;
        h  = n % 16;
        v  = (n / 16) % 11;
        fc = FC_ON ? ((n / S_FRAME) + (((n % S_FRAME) >= 96) ? 1 : 0)) % 256 : 0;
        return {pack_exp(h, v, (h < 8) && (v < 6), !((h >= 10) && (h <= 12)),
                         !((v >= 7) && (v <= 8)), h == 0, (h == 0) && (v == 0),
                         (h == 0) && (v == 6)), 8'(fc)};
    endfunction

    initial begin
        int vi;
        int disp_cnt, hs_low_cnt, ls_cnt, fs_cnt;
        bit found;

        vecs[0]  = '{0,    0,   0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{639,  639, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{640,  640, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{655,  655, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{656,  656, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{751,  751, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{752,  752, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{799,  799, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{800,  0,   1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{7999, 799, 9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8000, 0,   10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{8639, 639, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8640, 640, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8656, 656, 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (5) step();
        check("reset_big",        64'(big_act()),     64'(pack_exp(799, 524, 0, 1, 1, 0, 0, 0)));
        check("reset_big_fc",     64'(frame_count),   64'd0);
        check("reset_small",      64'(small_act()),   64'(pack_exp(15, 10, 0, 1, 1, 0, 0, 0)));
        check("reset_small_fc",   64'(s_frame_count), 64'd0);

        rst_n = 1'b1;
        vi = 0;
        disp_cnt = 0; hs_low_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        for (int n = 0; n <= N_END; n++) begin
            step();
            if (vi < 14) begin
                if (vecs[vi].n == n) begin
                    check($sformatf("vec_n%0d", n), 64'(big_act()),
                          64'(pack_exp(vecs[vi].h, vecs[vi].v, vecs[vi].d, vecs[vi].hs,
                                       vecs[vi].vs, vecs[vi].ls, vecs[vi].fs, vecs[vi].vb)));
                    vi++;
                end
            end
            if (n < 8800) begin
                if (frame_count !== 8'd0) check($sformatf("big_fc_n%0d", n), 64'(frame_count), 64'd0);
            end
            if (n >= 8000 && n <= 8799) begin
                disp_cnt   += display_on ? 1 : 0;
                hs_low_cnt += hsync ? 0 : 1;
                ls_cnt     += line_start ? 1 : 0;
                fs_cnt     += frame_start ? 1 : 0;
            end
            if (n < 3 * S_FRAME) begin
                check($sformatf("small_n%0d", n), 64'({small_act(), s_frame_count}), 64'(small_model(n)));
            end
            if (n == 447) check("fc_before_3rd", 64'(s_frame_count), FC_ON ? 64'd2 : 64'd0);
            if (n == 448) check("fc_after_3rd",  64'(s_frame_count), FC_ON ? 64'd3 : 64'd0);
            if (n == N_END - 1) check("fc_255", 64'(s_frame_count), FC_ON ? 64'd255 : 64'd0);
            if (n == N_END) begin
                check("fc_wrap", 64'(s_frame_count), FC_ON ? 64'd0 : 64'd0);
                check("fc_wrap_vblank", 64'(small_act()), 64'(pack_exp(0, 6, 0, 1, 1, 1, 0, 1)));
            end
        end
        check("vectors_applied", 64'(vi), 64'd14);
        check("line10_display_clks", 64'(disp_cnt),   64'd640);
        check("line10_hsync_low",    64'(hs_low_cnt), 64'd96);
        check("line10_line_start",   64'(ls_cnt),     64'd1);
        check("line10_frame_start",  64'(fs_cnt),     64'd0);

        // Mid-frame reset once the small raster sits at (5,4)
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
            if (s_hpos == 10'd5 && s_vpos == 10'd4) found = 1'b1;
            else step();
        end
        check("midframe_reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        step();
        check("midrst_small",    64'(small_act()),   64'(pack_exp(15, 10, 0, 1, 1, 0, 0, 0)));
        check("midrst_small_fc", 64'(s_frame_count), 64'd0);
        check("midrst_big",      64'(big_act()),     64'(pack_exp(799, 524, 0, 1, 1, 0, 0, 0)));
        check("midrst_big_fc",   64'(frame_count),   64'd0);
        step();
        check("midrst_hold",     64'(small_act()),   64'(pack_exp(15, 10, 0, 1, 1, 0, 0, 0)));
        rst_n = 1'b1;
        step();
        check("rerelease_small", 64'(small_act()),   64'(pack_exp(0, 0, 1, 1, 1, 1, 1, 0)));
        check("rerelease_big",   64'(big_act()),     64'(pack_exp(0, 0, 1, 1, 1, 1, 1, 0)));
        step();
        check("rerelease_next",  64'(small_act()),   64'(pack_exp(1, 0, 1, 1, 1, 0, 0, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream raster timing source for the VGA pixel pipelines, including the CA renderer.
- Produces hsync/vsync, display_on and pixel coordinates hpos/vpos, all aligned in the same cycle.
- Also produces single-cycle line/frame/vblank strobes, so consumers do not have to re-decode coordinates.
- Runs at the pixel clock (25.175 MHz nominal), one pixel per clk.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, output level of hsync/vsync during the pulse (0 = active-low)
POS_W, 10, width of hpos/vpos; H_TOTAL and V_TOTAL must each be <= 2^POS_W
FRAME_W, 8, frame counter width

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, synchronous, active-low
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
hpos  out  POS_W  current column, 0..H_TOTAL-1
vpos  out  POS_W  current line, 0..V_TOTAL-1
line_start  out  1  pulse when hpos==0
frame_start  out  1  pulse when hpos==0 and vpos==0
vblank_start  out  1  pulse when hpos==0 and vpos==V_DISPLAY
frame_count  out  FRAME_W  completed visible frames, wrapping

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- hpos increments every clk. At H_TOTAL-1 it wraps to 0 and vpos increments. vpos wraps from V_TOTAL-1 to 0 in the same cycle.
- All outputs are registered and consistent with the registered hpos/vpos of the same cycle. Decode uses next-state counter values; there is no combinational path from counters to ports.
- hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- vsync is active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491, over the whole line.
- Reset (rst_n low at clk edge):
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1.
  - hsync/vsync inactive (=~SYNC_POL).
  - display_on=0, all strobes 0, frame_count=0.
  - Reset is held for as long as rst_n is low.
- First edge after release yields hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: the next edge forces the reset state immediately. There is no partial-frame completion and no strobe is emitted.
- Strobes are exactly one clk wide. frame_start and line_start coincide. vblank_start coincides with line_start.
- frame_count increments (mod 2^FRAME_W) in the cycle vblank_start is high. The first increment occurs 480 lines after reset release.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN
- Defined: frame_count counter is implemented as described above.
- Undefined:
  - The counter register is not instantiated.
  - frame_count is tied to 0.
  - All other outputs are cycle-identical to the defined build.

Decomposition:
- Package vga_timing_pkg:
  - 640x480@60 timing constants (the H_*/V_* defaults and the derived H_TOTAL=800, V_TOTAL=525).
  - localparam POS_W.
  - Sync-polarity constants.
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical):
  - Parameterised DISPLAY/FRONT/SYNC/BACK.
  - Inputs: clk, rst_n, advance.
  - Outputs: pos, wrap (pulse on the last count when advance is high), active, sync_pulse.
  - Horizontal instance: advance=1.
  - Vertical instance: advance=horizontal wrap.

Test Plan:
- Hold rst_n=0 for 5 clks: hpos=799, vpos=524, hsync=vsync=1, display_on=0. Release: next cycle hpos=0, vpos=0, display_on=1, line_start=frame_start=1.
- Sample one line at vpos=10: display_on high exactly for hpos 0..639 (640 clks); hsync low exactly for hpos 656..751 (96 clks); line_start high only at hpos=0.
- Full frame: vsync low exactly for vpos 490..491 (1600 clks); frame_start pulses spaced 420000 clks; vblank_start at vpos=480, hpos=0.
- Wrap boundaries: (799,9)->(0,10); (799,524)->(0,0) with frame_start=1.
- Reset mid-frame at hpos=300, vpos=200: next edge hpos=799, vpos=524, display_on=0, frame_count=0, no strobes.
- VGA_FRAME_COUNT_EN defined:
  - After 3 vblank_start pulses, frame_count=3.
  - Preload 255 via 255 frames; next vblank_start gives 0.
  - Undefined build: frame_count stays 0 and all other outputs match the defined build.
